// File: rtl/writeback_commit_pkg.sv
// Shared types for the execute -> writeback boundary: result bundle and condition codes.
// The result bundle is defined here so execute and writeback use the same field layout.
package writeback_commit_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam logic [REG_AW-1:0] PC_REG = 3'd7;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_C      = 2'b10,
        COND_RSVD   = 2'b11
    } cond_e;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] result;
        logic              rf_we;
        logic              c;
        logic              z;
        logic              c_we;
        logic              z_we;
        cond_e             cond;
    } wb_bundle_t;

    // The reserved code executes unconditionally, the same as COND_ALWAYS.
    function automatic logic cond_pass(input cond_e cond, input logic c, input logic z);
        case (cond)
            COND_C:  return c;
            COND_Z:  return z;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/writeback_commit_result_fifo.sv
// In-order synchronous FIFO of writeback bundles with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo
    import writeback_commit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  wb_bundle_t    wdata_i,
    output wb_bundle_t    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    wb_bundle_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; an entry is only read once the count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit stage: buffers execute results, applies C/Z conditional execution,
// drives the register-file write port, owns the architectural flags and retire counter.
module writeback_commit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_rf_we,
    input  logic              ex_c,
    input  logic              ex_z,
    input  logic              ex_c_we,
    input  logic              ex_z_we,
    input  logic [1:0]        ex_cond,
    input  logic              wb_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              c_flag,
    output logic              z_flag,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic [CNT_W-1:0]  retire_cnt
);

    import writeback_commit_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    wb_bundle_t    in_b, head_b;
    logic          push, pop, commit;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              c_q, c_d, z_q, z_d;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] pc_target_q, pc_target_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    always_comb begin
        in_b        = '0;
        in_b.dest   = ex_dest;
        in_b.result = ex_result;
        in_b.rf_we  = ex_rf_we;
        in_b.c      = ex_c;
        in_b.z      = ex_z;
        in_b.c_we   = ex_c_we;
        in_b.z_we   = ex_z_we;
        in_b.cond   = cond_e'(ex_cond);
    end

    // Readiness comes only from the registered count, never from ex_valid.
    assign ex_ready = (fifo_cnt < CW'(DEPTH));
    assign push     = ex_valid & ~fifo_full;
    assign pop      = ~fifo_empty & ~wb_stall;

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_b),
        .rdata_o (head_b),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // The head is judged against the live flag registers; older entries have already updated them.
    always_comb begin
        commit      = pop & cond_pass(head_b.cond, c_q, z_q);
        rf_we_d     = commit & head_b.rf_we;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        c_d         = c_q;
        z_d         = z_q;
        pc_target_d = pc_target_q;
        if (rf_we_d) begin
            rf_addr_d = head_b.dest;
            rf_data_d = head_b.result;
        end
        if (commit && head_b.c_we) c_d = head_b.c;
        if (commit && head_b.z_we) z_d = head_b.z;
        redirect_d = rf_we_d & (head_b.dest == PC_REG);
        if (redirect_d) pc_target_d = head_b.result;
        retire_d = retire_q + CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            redirect_q  <= 1'b0;
            pc_target_q <= '0;
            retire_q    <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            c_q         <= c_d;
            z_q         <= z_d;
            redirect_q  <= redirect_d;
            pc_target_q <= pc_target_d;
            retire_q    <= retire_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_addr     = rf_addr_q;
    assign rf_data     = rf_data_q;
    assign c_flag      = c_q;
    assign z_flag      = z_q;
    assign pc_redirect = redirect_q;
    assign pc_target   = pc_target_q;
    assign retire_cnt  = retire_q;

endmodule
